// File: rtl/vend_pkg.sv
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and constants for the vending controller slice:
//            state encoding, coin values and money width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

   localparam int MONEY_W = 8;

   typedef logic [MONEY_W-1:0] money_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_PAY    = 3'd2,
      ST_DONE   = 3'd3,
      ST_REFUND = 3'd4
   } state_t;

   localparam money_t COIN_ONE    = 8'd1;
   localparam money_t COIN_FIVE   = 8'd5;
   localparam money_t COIN_TEN    = 8'd10;
   localparam money_t COIN_TWENTY = 8'd20;
   localparam money_t COIN_FIFTY  = 8'd50;

endpackage

`default_nettype wire

// File: rtl/vend_controller_if.sv
// ============================================================================
// Module   : vend_controller_if
// Purpose  : Key/coin pulse inputs and registered display-side outputs of the
//            vending controller. master = pulse source, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vend_controller_if;
   import vend_pkg::*;

   logic       goods_p;
   logic       confirm_p;
   logic       change_p;
   logic       cancel_p;
   logic       coin_one_p;
   logic       coin_five_p;
   logic       coin_ten_p;
   logic       coin_twenty_p;
   logic       coin_fifty_p;

   money_t     need_money;
   money_t     input_money;
   money_t     change_money;
   logic [1:0] goods_idx;
   logic [2:0] state_o;
   logic       dispense;
   logic       coin_reject;

   modport master (
      output goods_p, confirm_p, change_p, cancel_p,
      output coin_one_p, coin_five_p, coin_ten_p, coin_twenty_p, coin_fifty_p,
      input  need_money, input_money, change_money, goods_idx, state_o,
      input  dispense, coin_reject
   );

   modport slave (
      input  goods_p, confirm_p, change_p, cancel_p,
      input  coin_one_p, coin_five_p, coin_ten_p, coin_twenty_p, coin_fifty_p,
      output need_money, input_money, change_money, goods_idx, state_o,
      output dispense, coin_reject
   );

endinterface

`default_nettype wire

// File: rtl/vend_timer.sv
// ============================================================================
// Module   : vend_timer
// Purpose  : Loadable down-counter that saturates at zero; o_done is high
//            while the count is zero. Shared by the hold and timeout paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_timer #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_load_val,
   output logic                  o_done
);

   logic [WIDTH-1:0] r_count;

   // Load takes priority; otherwise count down and stick at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vend_controller.sv
// ============================================================================
// Module   : vend_controller
// Purpose  : Select/pay/dispense/refund transaction FSM of the vending
//            machine. All outputs registered.
//            Optional macro VEND_TIMEOUT_EN adds an inactivity timeout in
//            SELECT/PAY using the shared vend_timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_controller
   import vend_pkg::*;
#(
   parameter money_t      PRICE0         = 8'd3,
   parameter money_t      PRICE1         = 8'd5,
   parameter money_t      PRICE2         = 8'd9,
   parameter money_t      PRICE3         = 8'd13,
   parameter logic [31:0] HOLD_CYCLES    = 32'd100_000_000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
   input  wire logic        sys_clk,
   input  wire logic        sys_rst_n,
   vend_controller_if.slave bus
);

   state_t       r_state, w_state_nx;
   logic [1:0]   r_idx, w_idx_nx;
   money_t       r_need, w_need_nx;
   money_t       r_in, w_in_nx;
   money_t       r_chg, w_chg_nx;
   logic         r_disp, w_disp_nx;
   logic         r_rej, w_rej_nx;

   logic [MONEY_W:0] w_coin_sum;
   logic [MONEY_W:0] w_sum_total;
   logic             w_coin_any;
   logic             w_coin_ok;
   money_t           w_paid;
   logic [1:0]       w_idx_inc;
   logic             w_hold_load;
   logic             w_to_load;
   logic             w_tmr_done;
   logic [31:0]      w_tmr_val;

   function automatic money_t f_price(input logic [1:0] idx);
      case (idx)
         2'd0:    f_price = PRICE0;
         2'd1:    f_price = PRICE1;
         2'd2:    f_price = PRICE2;
         default: f_price = PRICE3;
      endcase
   endfunction

   // Same-cycle coins are summed one bit wider so overflow past 255 is visible.
   assign w_coin_sum = (bus.coin_one_p    ? {1'b0, COIN_ONE}    : '0)
                     + (bus.coin_five_p   ? {1'b0, COIN_FIVE}   : '0)
                     + (bus.coin_ten_p    ? {1'b0, COIN_TEN}    : '0)
                     + (bus.coin_twenty_p ? {1'b0, COIN_TWENTY} : '0)
                     + (bus.coin_fifty_p  ? {1'b0, COIN_FIFTY}  : '0);
   assign w_sum_total = {1'b0, r_in} + w_coin_sum;
   assign w_coin_any  = bus.coin_one_p | bus.coin_five_p | bus.coin_ten_p
                      | bus.coin_twenty_p | bus.coin_fifty_p;
   // Cancel outranks coins, so coins arriving with a cancel are rejected.
   assign w_coin_ok   = w_coin_any && (r_state == ST_PAY) && !bus.cancel_p
                      && !w_sum_total[MONEY_W];
   assign w_paid      = w_coin_ok ? w_sum_total[MONEY_W-1:0] : r_in;
   assign w_idx_inc   = r_idx + 2'd1;

`ifdef VEND_TIMEOUT_EN
   logic w_activity;
   assign w_activity = bus.goods_p | bus.confirm_p | bus.change_p | bus.cancel_p | w_coin_any;
   assign w_to_load  = w_activity && ((w_state_nx == ST_SELECT) || (w_state_nx == ST_PAY));
`else
   assign w_to_load  = 1'b0;
`endif

   // Hold count is armed on the transition into DONE or REFUND.
   assign w_hold_load = ((w_state_nx == ST_DONE) || (w_state_nx == ST_REFUND))
                     && (w_state_nx != r_state);
   assign w_tmr_val   = w_hold_load ? (HOLD_CYCLES - 32'd1) : (TIMEOUT_CYCLES - 32'd1);

   vend_timer #(.WIDTH(32)) u_timer (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .i_load     (w_hold_load | w_to_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

   // State and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_need  <= '0;
         r_in    <= '0;
         r_chg   <= '0;
         r_disp  <= 1'b0;
         r_rej   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_need  <= w_need_nx;
         r_in    <= w_in_nx;
         r_chg   <= w_chg_nx;
         r_disp  <= w_disp_nx;
         r_rej   <= w_rej_nx;
      end
   end

   // Next-state and next-output decode, priority cancel > coins > confirm/change > goods.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_need_nx  = r_need;
      w_in_nx    = r_in;
      w_chg_nx   = r_chg;
      w_disp_nx  = 1'b0;
      w_rej_nx   = w_coin_any & ~w_coin_ok;
      case (r_state)
         ST_IDLE: begin
            if (bus.goods_p && !bus.cancel_p) begin
               w_state_nx = ST_SELECT;
               w_idx_nx   = 2'd0;
               w_need_nx  = PRICE0;
            end
         end
         ST_SELECT: begin
            if (bus.cancel_p) begin
               w_state_nx = ST_IDLE;
               w_idx_nx   = '0;
               w_need_nx  = '0;
            end else if (bus.confirm_p) begin
               w_state_nx = ST_PAY;
            end else if (bus.goods_p) begin
               w_idx_nx   = w_idx_inc;
               w_need_nx  = f_price(w_idx_inc);
`ifdef VEND_TIMEOUT_EN
            end else if (!w_activity && w_tmr_done) begin
               w_state_nx = ST_IDLE;
               w_idx_nx   = '0;
               w_need_nx  = '0;
`endif
            end
         end
         ST_PAY: begin
            if (bus.cancel_p) begin
               if (r_in != '0) begin
                  w_state_nx = ST_REFUND;
                  w_chg_nx   = r_in;
               end else begin
                  w_state_nx = ST_IDLE;
                  w_idx_nx   = '0;
                  w_need_nx  = '0;
               end
            end else begin
               w_in_nx = w_paid;
               if ((bus.confirm_p || bus.change_p) && (w_paid >= r_need)) begin
                  w_state_nx = ST_DONE;
                  w_chg_nx   = w_paid - r_need;
                  w_disp_nx  = 1'b1;
`ifdef VEND_TIMEOUT_EN
               end else if (!w_activity && w_tmr_done) begin
                  if (r_in != '0) begin
                     w_state_nx = ST_REFUND;
                     w_chg_nx   = r_in;
                  end else begin
                     w_state_nx = ST_IDLE;
                     w_idx_nx   = '0;
                     w_need_nx  = '0;
                  end
`endif
               end
            end
         end
         ST_DONE, ST_REFUND: begin
            if (bus.change_p || w_tmr_done) begin
               w_state_nx = ST_IDLE;
               w_idx_nx   = '0;
               w_need_nx  = '0;
               w_in_nx    = '0;
               w_chg_nx   = '0;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
            w_need_nx  = '0;
            w_in_nx    = '0;
            w_chg_nx   = '0;
         end
      endcase
   end

   assign bus.state_o      = r_state;
   assign bus.goods_idx    = r_idx;
   assign bus.need_money   = r_need;
   assign bus.input_money  = r_in;
   assign bus.change_money = r_chg;
   assign bus.dispense     = r_disp;
   assign bus.coin_reject  = r_rej;

endmodule

`default_nettype wire

// File: tb/tb_vend_controller.sv
// ============================================================================
// Module   : tb_vend_controller
// Purpose  : Scoreboard bench for vend_controller. Expected output snapshots
//            are queued with each stimulus and compared once the DUT updates.
//            Honors VEND_TIMEOUT_EN to pick the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_controller;

   localparam int HOLD = 20;
   localparam int TOUT = 50;

   // Pulse vector bit order: goods, confirm, change, cancel, c1, c5, c10, c20, c50.
   localparam logic [8:0] K_G  = 9'h100;
   localparam logic [8:0] K_CF = 9'h080;
   localparam logic [8:0] K_CH = 9'h040;
   localparam logic [8:0] K_CA = 9'h020;
   localparam logic [8:0] K_1  = 9'h010;
   localparam logic [8:0] K_5  = 9'h008;
   localparam logic [8:0] K_10 = 9'h004;
   localparam logic [8:0] K_20 = 9'h002;
   localparam logic [8:0] K_50 = 9'h001;

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] need;
      logic [7:0] in;
      logic [7:0] chg;
      logic [1:0] idx;
      logic       disp;
      logic       rej;
   } snap_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   snap_t sb_q[$];

   vend_controller_if bus();

   vend_controller #(
      .PRICE0         (8'd3),
      .PRICE1         (8'd5),
      .PRICE2         (8'd9),
      .PRICE3         (8'd13),
      .HOLD_CYCLES    (32'(HOLD)),
      .TIMEOUT_CYCLES (32'(TOUT))
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   function automatic snap_t mk(input int st, input int need, input int in,
                                input int chg, input int idx, input int d, input int r);
      snap_t s;
      s.st = 3'(st); s.need = 8'(need); s.in = 8'(in); s.chg = 8'(chg);
      s.idx = 2'(idx); s.disp = 1'(d); s.rej = 1'(r);
      return s;
   endfunction

   function automatic snap_t cur();
      return {bus.state_o, bus.need_money, bus.input_money, bus.change_money,
              bus.goods_idx, bus.dispense, bus.coin_reject};
   endfunction

   task automatic drive(input logic [8:0] k);
      {bus.goods_p, bus.confirm_p, bus.change_p, bus.cancel_p, bus.coin_one_p,
       bus.coin_five_p, bus.coin_ten_p, bus.coin_twenty_p, bus.coin_fifty_p} = k;
   endtask

   task automatic pulse(input logic [8:0] k);
      @(negedge clk);
      drive(k);
      @(posedge clk);
      #1;
      drive(9'h000);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      snap_t g, e;
      drive(9'h000);
      rst_n = 1'b0;
      tick(3);
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL reset_held: actual %h required %h", g, e); end
      @(negedge clk); rst_n = 1'b1;
      tick(2);
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL reset_idle: actual %h required %h", g, e); end
   endtask

   task automatic test_purchase();
      logic [8:0] k [5];
      snap_t x [5];
      snap_t g, e;
      k = '{K_G, K_G, K_CF, K_10, K_CF};
      x = '{mk(1,3,0,0,0,0,0), mk(1,5,0,0,1,0,0), mk(2,5,0,0,1,0,0),
            mk(2,5,10,0,1,0,0), mk(3,5,10,5,1,1,0)};
      for (int i = 0; i < 5; i++) begin
         sb_q.push_back(x[i]); pulse(k[i]);
         g = cur(); e = sb_q.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL purchase[%0d]: actual %h required %h", i, g, e); end
      end
      sb_q.push_back(mk(3, 5, 10, 5, 1, 0, 0)); tick(HOLD - 1);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL purchase_hold_last: actual %h required %h", g, e); end
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); tick(1);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL purchase_hold_exit: actual %h required %h", g, e); end
   endtask

   task automatic test_wrap();
      logic [8:0] k [6];
      snap_t x [6];
      snap_t g, e;
      k = '{K_G, K_G, K_G, K_G, K_G, K_CA};
      x = '{mk(1,3,0,0,0,0,0), mk(1,5,0,0,1,0,0), mk(1,9,0,0,2,0,0),
            mk(1,13,0,0,3,0,0), mk(1,3,0,0,0,0,0), mk(0,0,0,0,0,0,0)};
      for (int i = 0; i < 6; i++) begin
         sb_q.push_back(x[i]); pulse(k[i]);
         g = cur(); e = sb_q.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL wrap[%0d]: actual %h required %h", i, g, e); end
      end
   endtask

   task automatic test_insufficient();
      logic [8:0] k [10];
      snap_t x [10];
      snap_t g, e;
      k = '{K_G, K_G, K_G, K_G, K_CF, K_10, K_CF, K_5, K_CF, K_CH};
      x = '{mk(1,3,0,0,0,0,0), mk(1,5,0,0,1,0,0), mk(1,9,0,0,2,0,0),
            mk(1,13,0,0,3,0,0), mk(2,13,0,0,3,0,0), mk(2,13,10,0,3,0,0),
            mk(2,13,10,0,3,0,0), mk(2,13,15,0,3,0,0), mk(3,13,15,2,3,1,0),
            mk(0,0,0,0,0,0,0)};
      for (int i = 0; i < 10; i++) begin
         sb_q.push_back(x[i]); pulse(k[i]);
         g = cur(); e = sb_q.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL insufficient[%0d]: actual %h required %h", i, g, e); end
      end
   endtask

   task automatic test_overflow();
      logic [8:0] k [16];
      snap_t x [16];
      snap_t g, e;
      k = '{K_G, K_CF, K_50, K_50, K_50, K_50, K_50, K_10, K_CA, K_CH,
            K_G, K_CF, K_1 | K_5, K_CA | K_5, K_CH, K_5};
      x = '{mk(1,3,0,0,0,0,0), mk(2,3,0,0,0,0,0), mk(2,3,50,0,0,0,0),
            mk(2,3,100,0,0,0,0), mk(2,3,150,0,0,0,0), mk(2,3,200,0,0,0,0),
            mk(2,3,250,0,0,0,0), mk(2,3,250,0,0,0,1), mk(4,3,250,250,0,0,0),
            mk(0,0,0,0,0,0,0), mk(1,3,0,0,0,0,0), mk(2,3,0,0,0,0,0),
            mk(2,3,6,0,0,0,0), mk(4,3,6,6,0,0,1), mk(0,0,0,0,0,0,0),
            mk(0,0,0,0,0,0,1)};
      for (int i = 0; i < 16; i++) begin
         sb_q.push_back(x[i]); pulse(k[i]);
         g = cur(); e = sb_q.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL overflow[%0d]: actual %h required %h", i, g, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] k [7];
      snap_t x [7];
      snap_t g, e;
      k = '{K_G, K_CF, K_5 | K_CF, K_CH, K_G, K_CF, K_CA};
      x = '{mk(1,3,0,0,0,0,0), mk(2,3,0,0,0,0,0), mk(3,3,5,2,0,1,0),
            mk(0,0,0,0,0,0,0), mk(1,3,0,0,0,0,0), mk(2,3,0,0,0,0,0),
            mk(0,0,0,0,0,0,0)};
      for (int i = 0; i < 7; i++) begin
         sb_q.push_back(x[i]); pulse(k[i]);
         g = cur(); e = sb_q.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL back_to_back[%0d]: actual %h required %h", i, g, e); end
      end
   endtask

   task automatic test_refund();
      logic [8:0] k [4];
      snap_t x [4];
      snap_t g, e;
      k = '{K_G, K_CF, K_20, K_CA};
      x = '{mk(1,3,0,0,0,0,0), mk(2,3,0,0,0,0,0), mk(2,3,20,0,0,0,0),
            mk(4,3,20,20,0,0,0)};
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(x[i]); pulse(k[i]);
         g = cur(); e = sb_q.pop_front(); n_vec++;
         if (g !== e) begin n_err++; $display("FAIL refund[%0d]: actual %h required %h", i, g, e); end
      end
      sb_q.push_back(mk(4, 3, 20, 20, 0, 0, 0)); tick(HOLD - 1);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL refund_hold_last: actual %h required %h", g, e); end
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); tick(1);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL refund_hold_exit: actual %h required %h", g, e); end
   endtask

   task automatic test_reset_mid_pay();
      snap_t g, e;
      pulse(K_G); pulse(K_CF); pulse(K_10);
      sb_q.push_back(mk(2, 3, 10, 0, 0, 0, 0));
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL midpay_before_reset: actual %h required %h", g, e); end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL midpay_async_reset: actual %h required %h", g, e); end
      @(negedge clk); rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_timeout();
      snap_t g, e;
      pulse(K_G); pulse(K_CF); pulse(K_5);
      sb_q.push_back(mk(2, 3, 5, 0, 0, 0, 0));
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL timeout_pay_entry: actual %h required %h", g, e); end
`ifdef VEND_TIMEOUT_EN
      sb_q.push_back(mk(2, 3, 5, 0, 0, 0, 0)); tick(TOUT - 1);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL timeout_not_yet: actual %h required %h", g, e); end
      sb_q.push_back(mk(4, 3, 5, 5, 0, 0, 0)); tick(1);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL timeout_refund: actual %h required %h", g, e); end
`else
      sb_q.push_back(mk(2, 3, 5, 0, 0, 0, 0)); tick(100);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL no_timeout_wait: actual %h required %h", g, e); end
      pulse(K_CA);
`endif
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); pulse(K_CH);
      g = cur(); e = sb_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL timeout_exit: actual %h required %h", g, e); end
   endtask

   initial begin
      test_reset();
      test_purchase();
      test_wrap();
      test_insufficient();
      test_overflow();
      test_back_to_back();
      test_refund();
      test_reset_mid_pay();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vend_controller.md
# vend_controller

Core transaction controller of the micro vending machine. Sits between the key-debounce stage and the seven-segment display stage. Consumes one-cycle debounced key pulses and coin pulses, and runs the select/pay/dispense/refund state machine. Produces the registered `need_money`, `input_money` and `change_money` values that the display stage renders.

## Interface
Parameters:
- `PRICE0`, default 8'd3: price of goods item 0.
- `PRICE1`, default 8'd5: price of goods item 1.
- `PRICE2`, default 8'd9: price of goods item 2.
- `PRICE3`, default 8'd13: price of goods item 3.
- `HOLD_CYCLES`, default 32'd100_000_000: cycles that DONE/REFUND show change before returning to IDLE.
- `TIMEOUT_CYCLES`, default 32'd1_000_000_000: inactivity limit in SELECT/PAY. Used only with `VEND_TIMEOUT_EN`.

Ports:
- `sys_clk`, in, 1: system clock. Single clock domain.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `goods_p`, `confirm_p`, `change_p`, `cancel_p`, in, 1 each: debounced key pulses, one cycle wide.
- `coin_one_p`, `coin_five_p`, `coin_ten_p`, `coin_twenty_p`, `coin_fifty_p`, in, 1 each: coin pulses worth 1/5/10/20/50.
- `need_money`, out, 8: price of the selected item. 0 in IDLE.
- `input_money`, out, 8: accumulated inserted value.
- `change_money`, out, 8: change or refund value. Nonzero only in DONE/REFUND.
- `goods_idx`, out, 2: selected item index.
- `state_o`, out, 3: current state encoding.
- `dispense`, out, 1: one-cycle pulse on entry to DONE.
- `coin_reject`, out, 1: one-cycle pulse when a coin is not accepted.

## Operation
States and encodings: IDLE=0, SELECT=1, PAY=2, DONE=3, REFUND=4.

- **IDLE**: all money outputs 0.
  - `goods_p` → SELECT with `goods_idx`=0 and `need_money`=PRICE0.
- **SELECT**:
  - `goods_p` → `goods_idx`+1, wrapping 3→0; `need_money` tracks the price.
  - `confirm_p` → PAY.
  - `cancel_p` → IDLE.
- **PAY**: coins accumulate into `input_money`.
  - `confirm_p` or `change_p` with `input_money` ≥ `need_money` → DONE, `change_money` = `input_money` − `need_money`, and `dispense` pulses.
  - `confirm_p` or `change_p` with insufficient money → ignored.
  - `cancel_p` with `input_money`>0 → REFUND, `change_money` = `input_money`.
  - `cancel_p` with `input_money`=0 → IDLE.
  - `goods_p` → ignored.
- **DONE / REFUND**: hold outputs for HOLD_CYCLES, then go to IDLE and clear all money outputs and `goods_idx`.
  - `change_p` → immediate return to IDLE.
  - All other inputs ignored.

Arithmetic:
- Coins arriving in the same cycle are summed.
- If the sum plus `input_money` exceeds 255, or the state is not PAY, every coin that cycle is discarded and `coin_reject` pulses.
- `input_money` never wraps.

Simultaneous events, priority highest first: `cancel_p`, then coins, then `confirm_p`/`change_p`, then `goods_p`.
- A coin and a confirm in the same PAY cycle: the coin is added first, and sufficiency is evaluated on the new total.
- A cancel together with coins: the coins are rejected, and the refund equals the prior total.

Reset:
- Reset at any point, including mid-PAY, forces IDLE.
- All outputs go to 0. No refund is reported.

## Timing
- All outputs are registered.
- A pulse sampled at edge N is reflected in `state_o` and the money outputs after edge N (visible in cycle N+1).
- `dispense` and `coin_reject` are high for exactly one cycle.
- The hold counter starts at DONE/REFUND entry. The exit occurs on the cycle after count HOLD_CYCLES−1.
- Back-to-back input pulses on consecutive cycles are each processed.

## Configuration
- `VEND_TIMEOUT_EN` defined: an inactivity counter runs in SELECT and PAY.
  - The counter clears on any key or coin pulse.
  - On reaching TIMEOUT_CYCLES: SELECT → IDLE. PAY → REFUND if `input_money`>0, else IDLE.
- `VEND_TIMEOUT_EN` undefined: no counter is synthesized, and SELECT/PAY wait indefinitely.

## Structure
- Shared package `vend_pkg` holds:
  - the state enum and its encodings;
  - coin value constants (1/5/10/20/50);
  - money width `MONEY_W`=8.
- One sub-module, `vend_timer`: a loadable down-counter with a `done` flag. It is shared by the hold and timeout functions, which are never active together.

## Test plan
- Purchase with change: goods, goods, confirm (item 1, price 5), coin_ten, confirm → DONE, `change_money`=5, `dispense` pulse, IDLE after HOLD_CYCLES.
- Item wrap: five `goods_p` pulses from IDLE → `goods_idx`=0, `need_money`=3 after the 1st and 5th pulses.
- Insufficient funds: item 3 (13), coin_ten, confirm → stays PAY, `input_money`=10. Then coin_five → confirm → DONE, `change_money`=2.
- Overflow: in PAY, five coin_fifty pulses (250), then coin_ten → `coin_reject` pulse, `input_money`=250. Simultaneous coin_one+coin_five on 0 → `input_money`=6.
- Cancel refund and reset: PAY with 20 inserted, `cancel_p` → REFUND with `change_money`=20. Separately, assert `sys_rst_n` low mid-PAY → all outputs 0, `state_o`=0 asynchronously.
- With `VEND_TIMEOUT_EN`, TIMEOUT_CYCLES=50: PAY with 5 inserted and no activity for 50 cycles → REFUND with `change_money`=5. Without the macro, still in PAY after 100 cycles.
